// File: rtl/prim_filter_tx.sv
// Transmit-side level driver: queues requested levels and holds each on tx_o for HoldCycles clocks.
// Optional macro PRIM_FILTER_TX_DROP_DUP_EN discards queued levels equal to the current line level.
module prim_filter_tx #(
    parameter int unsigned HoldCycles = 4,
    parameter int unsigned Depth      = 4,
    parameter logic        ResetLevel = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic valid_i,
    input  logic data_i,
    output logic ready_o,
    output logic tx_o,
    output logic busy_o
);

    localparam int unsigned HcW  = $clog2(HoldCycles);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [HcW-1:0] HoldReload = HcW'(HoldCycles - 1);

`ifdef PRIM_FILTER_TX_DROP_DUP_EN
    localparam bit DropDup = 1'b1;
`else
    localparam bit DropDup = 1'b0;
`endif

    typedef enum logic {IDLE, HOLD} state_e;

    state_e            state_q, state_d;
    logic              tx_q, tx_d;
    logic [HcW-1:0]    hold_q, hold_d;
    logic [Depth-1:0]  fifo_q;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              full, empty, push, pop, head, last_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CntW'(Depth));
    assign head     = fifo_q[rd_ptr_q];
    assign ready_o  = enable_i & ~full & ~rst_i;
    assign push     = valid_i & ready_o;
    // Registered count only, so an entry pushed this cycle can never be popped this cycle.
    assign pop      = enable_i & ~empty & ((state_q == IDLE) | (hold_q == '0));
    assign last_pop = (cnt_q == CntW'(1)) & ~push;

    assign tx_o   = enable_i ? tx_q : data_i;
    assign busy_o = (state_q == HOLD) | ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (!enable_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        if (!enable_i) begin
            state_d = IDLE;
            hold_d  = '0;
            tx_d    = data_i;
        end else begin
            if (state_q == HOLD && hold_q != '0) hold_d = hold_q - HcW'(1);
            if (pop) begin
                if (!DropDup || head != tx_q) begin
                    tx_d    = head;
                    hold_d  = HoldReload;
                    state_d = HOLD;
                end else if (state_q == HOLD && last_pop) begin
                    state_d = IDLE;
                end
            end else if (state_q == HOLD && hold_q == '0 && empty) begin
                state_d = IDLE;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            tx_q     <= ResetLevel;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: FIFO storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: tb/tb_prim_filter_tx.sv
// Scoreboard bench for prim_filter_tx: expected tx_o transitions (level, edge) are queued by the
// stimulus and matched by a monitor that watches tx_o on every falling clock edge.
module tb_prim_filter_tx;

    logic clk = 1'b0;
    logic rst, enable, valid, data;
    logic ready, tx, busy;

    prim_filter_tx dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .enable_i(enable),
        .valid_i (valid),
        .data_i  (data),
        .ready_o (ready),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic val;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    bit   mon_en = 1'b0;
    logic prev_tx;

    task automatic expect_edge(input logic v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && tx !== prev_tx) begin
            if (sb.size() == 0) begin
                check("tx_unexpected_edge", {31'b0, tx}, {31'b0, prev_tx});
            end else begin
                e = sb.pop_front();
                check("tx_level", {31'b0, tx}, {31'b0, e.val});
                check("tx_edge", cyc, e.cyc);
            end
        end
        prev_tx = tx;
    end

    // Waits for ready at a falling edge, then returns the number of the accepting rising edge.
    task automatic push(input logic v, output int e);
        int n = 0;
        @(negedge clk);
        valid = 1'b1;
        data  = v;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", {31'b0, ready}, 1);
        @(posedge clk);
        #1;
        e = cyc;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_to(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, t, big_e, d0, f0, g0, idle_at;
        rst = 1'b1; enable = 1'b1; valid = 1'b0; data = 1'b0;

        // Reset state.
        #2;
        check("rst_tx", {31'b0, tx}, 0);
        check("rst_ready", {31'b0, ready}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        enable = 1'b0; data = 1'b1;
        #1 check("rst_bypass_tx", {31'b0, tx}, 1);
        enable = 1'b1; data = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, ready}, 1);
        check("post_rst_tx", {31'b0, tx}, 0);

        // Push 1,0,1 on consecutive edges: changes at e+1, e+5, e+9; idle at e+13.
        @(posedge clk);
        #1 mon_en = 1'b1;
        push(1'b1, e0);
        expect_edge(1'b1, e0 + 1);
        expect_edge(1'b0, e0 + 5);
        expect_edge(1'b1, e0 + 9);
        push(1'b0, t);
        check("seq_accept1", t, e0 + 1);
        push(1'b1, t);
        check("seq_accept2", t, e0 + 2);
        drop_valid();
        wait_to(e0 + 12);
        check("seq_busy_e12", {31'b0, busy}, 1);
        wait_to(e0 + 13);
        check("seq_busy_e13", {31'b0, busy}, 0);
        check("seq_sb_empty", sb.size(), 0);

        // Burst of alternating levels with valid held. The first entry pops immediately, so the
        // FIFO only fills at the fifth accept; the sixth waits for the next pop.
        push(1'b0, big_e);
        for (int i = 0; i < 6; i++) expect_edge(i[0] ? 1'b1 : 1'b0, big_e + 1 + 4 * i);
        for (int i = 1; i < 5; i++) begin
            push(i[0] ? 1'b1 : 1'b0, t);
            check("burst_accept", t, big_e + i);
        end
        @(negedge clk);
        check("full_ready_low", {31'b0, ready}, 0);
        push(1'b1, t);
        check("burst_accept_after_pop", t, big_e + 6);
        drop_valid();
        wait_to(big_e + 24);
        check("burst_busy_tail", {31'b0, busy}, 1);
        wait_to(big_e + 25);
        check("burst_idle", {31'b0, busy}, 0);

        // Force tx_q to 0 through bypass, then push a duplicate 0 followed by 1.
        mon_en = 1'b0;
        enable = 1'b0;
        data = 1'b0;
        #1 check("bypass_tx", {31'b0, tx}, 0);
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        push(1'b0, d0);
        push(1'b1, t);
        check("dup_accept", t, d0 + 1);
        drop_valid();
`ifdef PRIM_FILTER_TX_DROP_DUP_EN
        expect_edge(1'b1, d0 + 2);
        idle_at = d0 + 6;
`else
        expect_edge(1'b1, d0 + 5);
        idle_at = d0 + 9;
`endif
        wait_to(idle_at - 1);
        check("dup_busy", {31'b0, busy}, 1);
        wait_to(idle_at);
        check("dup_idle", {31'b0, busy}, 0);

        // Drop enable mid-hold: queued 1 is lost and the line never glitches.
        push(1'b0, f0);
        expect_edge(1'b0, f0 + 1);
        push(1'b1, t);
        check("abort_accept", t, f0 + 1);
        drop_valid();
        wait_to(f0 + 2);
        check("abort_busy_hold", {31'b0, busy}, 1);
        enable = 1'b0;
        data = 1'b0;
        #1;
        check("abort_tx_now", {31'b0, tx}, 0);
        check("abort_ready", {31'b0, ready}, 0);
        @(negedge clk);
        enable = 1'b1;
        #1;
        check("abort_flushed", {31'b0, busy}, 0);
        check("abort_ready_back", {31'b0, ready}, 1);
        check("abort_tx_reenable", {31'b0, tx}, 0);
        wait_to(f0 + 10);
        check("abort_tx_stays", {31'b0, tx}, 0);

        // Asynchronous reset mid-hold with two entries queued.
        push(1'b1, g0);
        expect_edge(1'b1, g0 + 1);
        push(1'b0, t);
        push(1'b1, t);
        check("arst_accept", t, g0 + 2);
        drop_valid();
        check("arst_busy_before", {31'b0, busy}, 1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_tx", {31'b0, tx}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_ready", {31'b0, ready}, 0);
        @(negedge clk);
        rst = 1'b0;

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
